mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter for the single word-wide memory port; runs fixed-length bursts.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration (default build uses D-over-I fixed priority).

`ifndef CACHE_B
`define CACHE_B 4
`endif

module mem_arbiter #(
    parameter int OFFSET_WIDTH = `CACHE_B,
    parameter int MEM_LATENCY  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [31:0]             i_addr,
    output logic                    i_gnt,
    output logic                    i_valid,
    output logic                    i_done,
    input  logic                    d_req,
    input  logic [31:0]             d_addr,
    input  logic                    d_wen,
    input  logic [31:0]             d_wdata,
    output logic                    d_gnt,
    output logic                    d_valid,
    output logic                    d_done,
    output logic [OFFSET_WIDTH-3:0] beat,
    output logic [31:0]             rdata,
    output logic                    stall,
    output logic [31:0]             maddr,
    output logic [31:0]             mwrite_data,
    output logic                    m_wen,
    input  logic [31:0]             mread_data
);

    localparam int BW    = OFFSET_WIDTH - 2;
    localparam int BEATS = 2 ** BW;
    localparam int CW    = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    localparam logic [CW-1:0] LAT_RELOAD = CW'(MEM_LATENCY);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [31:0]   LINE_MASK  = ~((32'd1 << OFFSET_WIDTH) - 32'd1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BURST   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // owner / last_owner encoding: 1 = D-side, 0 = I-side
    logic [1:0]    state_r;
    logic          owner_r;
    logic [31:0]   base_r;
    logic          is_wr_r;
    logic [BW-1:0] beat_r;
    logic [CW-1:0] wait_cnt_r;
    logic          last_owner_r;

    logic win_d_s;
    logic burst_s;
    logic commit_s;
    logic last_s;

    // Arbitration winner for the IDLE cycle
    always_comb begin
        win_d_s = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (d_req && i_req) begin
            win_d_s = ~last_owner_r;
        end else begin
            win_d_s = d_req;
        end
`else
        if (d_req) begin
            win_d_s = 1'b1;
        end else begin
            win_d_s = 1'b0;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_owner_s;
    assign unused_last_owner_s = last_owner_r;
`endif

    // Burst sequencer: grant, per-beat wait countdown, beat advance, release
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            base_r       <= 32'd0;
            is_wr_r      <= 1'b0;
            beat_r       <= '0;
            wait_cnt_r   <= '0;
            last_owner_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        owner_r    <= win_d_s;
                        base_r     <= (win_d_s ? d_addr : i_addr) & LINE_MASK;
                        is_wr_r    <= win_d_s & d_wen;
                        beat_r     <= '0;
                        wait_cnt_r <= LAT_RELOAD;
                        state_r    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (wait_cnt_r != '0) begin
                        wait_cnt_r <= wait_cnt_r - CW'(1);
                    end else if (beat_r == LAST_BEAT) begin
                        last_owner_r <= owner_r;
                        state_r      <= ST_RELEASE;
                    end else begin
                        beat_r     <= beat_r + BW'(1);
                        wait_cnt_r <= LAT_RELOAD;
                    end
                end
                ST_RELEASE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Port-side decode; everything is qualified by BURST so nothing leaks in IDLE/RELEASE
    always_comb begin
        burst_s  = (state_r == ST_BURST);
        commit_s = burst_s & (wait_cnt_r == '0);
        last_s   = (beat_r == LAST_BEAT);

        i_gnt   = burst_s & ~owner_r;
        d_gnt   = burst_s & owner_r;
        i_valid = commit_s & ~owner_r;
        d_valid = commit_s & owner_r;
        i_done  = commit_s & last_s & ~owner_r;
        d_done  = commit_s & last_s & owner_r;
        m_wen   = commit_s & is_wr_r;

        if (burst_s) begin
            maddr = base_r + (32'(beat_r) << 2);
        end else begin
            maddr = 32'd0;
        end

        if (burst_s && is_wr_r) begin
            mwrite_data = d_wdata;
        end else begin
            mwrite_data = 32'd0;
        end
    end

    assign beat  = beat_r;
    assign rdata = mread_data;
    assign stall = (i_req | d_req) & ~(i_done | d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: one instance at MEM_LATENCY=2, one at MEM_LATENCY=0, both with BEATS=4.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: OFFSET_WIDTH=4, MEM_LATENCY=2
    logic        i_req, i_gnt, i_valid, i_done;
    logic [31:0] i_addr;
    logic        d_req, d_wen, d_gnt, d_valid, d_done;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  beat;
    logic [31:0] rdata, maddr, mwrite_data, mread_data;
    logic        stall, m_wen;

    assign d_wdata    = 32'hA0 + {30'd0, beat};
    assign mread_data = maddr ^ 32'h5A5A_0000;

    mem_arbiter #(.OFFSET_WIDTH(4), .MEM_LATENCY(2)) dut_a (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_done(d_done),
        .beat(beat), .rdata(rdata), .stall(stall), .maddr(maddr),
        .mwrite_data(mwrite_data), .m_wen(m_wen), .mread_data(mread_data)
    );

    // Instance B: OFFSET_WIDTH=4, MEM_LATENCY=0
    logic        b_i_req, b_i_gnt, b_i_valid, b_i_done;
    logic [31:0] b_i_addr;
    logic        b_d_req, b_d_wen, b_d_gnt, b_d_valid, b_d_done;
    logic [31:0] b_d_addr, b_d_wdata;
    logic [1:0]  b_beat;
    logic [31:0] b_rdata, b_maddr, b_mwrite_data, b_mread_data;
    logic        b_stall, b_m_wen;

    assign b_d_wdata    = 32'd0;
    assign b_mread_data = b_maddr ^ 32'h5A5A_0000;

    mem_arbiter #(.OFFSET_WIDTH(4), .MEM_LATENCY(0)) dut_b (
        .clk(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_valid(b_i_valid), .i_done(b_i_done),
        .d_req(b_d_req), .d_addr(b_d_addr), .d_wen(b_d_wen), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_valid(b_d_valid), .d_done(b_d_done),
        .beat(b_beat), .rdata(b_rdata), .stall(b_stall), .maddr(b_maddr),
        .mwrite_data(b_mwrite_data), .m_wen(b_m_wen), .mread_data(b_mread_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run the current burst of one side to its done cycle, drop req, then pass RELEASE into IDLE
    task automatic finish_burst(input bit side_d);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (side_d ? d_done : i_done) begin
                seen = 1'b1;
                if (side_d) d_req = 1'b0;
                else        i_req = 1'b0;
            end
            step();
        end
        check("burst_done_seen", {31'd0, seen}, 32'd1);
        step();
    endtask

    initial begin
        int  eb;
        int  wen_cnt;
        int  gap;
        int  low;
        bit  got;
        bit  first_d;

        reset = 1'b1;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_addr = 32'd0; d_wen = 1'b0;
        b_i_req = 1'b0; b_i_addr = 32'd0;
        b_d_req = 1'b0; b_d_addr = 32'd0; b_d_wen = 1'b0;
        step();
        step();

        // Reset state
        check("rst_flags", {25'd0, i_gnt, d_gnt, i_valid, d_valid, i_done, d_done, m_wen}, 32'd0);
        check("rst_maddr", maddr, 32'd0);
        check("rst_wdata", mwrite_data, 32'd0);
        check("rst_beat", {30'd0, beat}, 32'd0);
        check("rst_stall_lo", {31'd0, stall}, 32'd0);
        i_req = 1'b1;
        #1;
        check("rst_stall_hi", {31'd0, stall}, 32'd1);
        i_req = 1'b0;
        reset = 1'b0;
        step();

        // 1: I-only refill of line 0x1230
        i_addr = 32'h0000_1238;
        i_req  = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            eb = (c - 1) / 3;
            check("t1_gnt", {31'd0, i_gnt}, 32'd1);
            check("t1_maddr", maddr, 32'h1230 + 32'(4 * eb));
            check("t1_valid", {31'd0, i_valid}, {31'd0, (c % 3 == 0)});
            check("t1_done", {31'd0, i_done}, {31'd0, (c == 12)});
            check("t1_wen", {31'd0, m_wen}, 32'd0);
            check("t1_stall", {31'd0, stall}, {31'd0, (c != 12)});
            if (c % 3 == 0) check("t1_rdata", rdata, (32'h1230 + 32'(4 * eb)) ^ 32'h5A5A_0000);
            if (c == 12) i_req = 1'b0;
            step();
        end
        check("t1_release_gnt", {31'd0, i_gnt}, 32'd0);
        step();
        check("t1_idle_gnt", {31'd0, i_gnt}, 32'd0);

        // 2: D write-back of line 0x40, data 0xA0+beat; d_wen toggled mid-burst must be ignored
        d_addr = 32'h40;
        d_wen  = 1'b1;
        d_req  = 1'b1;
        wen_cnt = 0;
        step();
        for (int c = 1; c <= 12; c++) begin
            eb = (c - 1) / 3;
            check("t2_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
            check("t2_wen", {31'd0, m_wen}, {31'd0, (c % 3 == 0)});
            check("t2_valid", {31'd0, d_valid}, {31'd0, (c % 3 == 0)});
            check("t2_done", {31'd0, d_done}, {31'd0, (c == 12)});
            check("t2_maddr", maddr, 32'h40 + 32'(4 * eb));
            check("t2_wdata", mwrite_data, 32'hA0 + 32'(eb));
            if (m_wen) wen_cnt++;
            if (c == 5) d_wen = 1'b0;
            if (c == 12) d_req = 1'b0;
            step();
        end
        check("t2_wen_count", 32'(wen_cnt), 32'd4);
        check("t2_release", {29'd0, d_gnt, m_wen, d_done}, 32'd0);
        check("t2_release_wdata", mwrite_data, 32'd0);
        step();

        // 3: simultaneous requests from reset
        reset  = 1'b1;
        i_addr = 32'h100;
        d_addr = 32'h200;
        d_wen  = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        step();
        reset = 1'b0;
        step();
`ifdef MEM_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        check("t3_first_i", {31'd0, i_gnt}, {31'd0, !first_d});
        check("t3_first_d", {31'd0, d_gnt}, {31'd0, first_d});
        got = 1'b0;
        gap = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            if (first_d ? d_done : i_done) begin
                if (first_d) d_req = 1'b0;
                else         i_req = 1'b0;
            end
            step();
            if (first_d ? i_gnt : d_gnt) begin
                got = 1'b1;
                gap = k;
            end
        end
        check("t3_second_seen", {31'd0, got}, 32'd1);
        check("t3_gap", 32'(gap), 32'd14);
        check("t3_second_addr", maddr, first_d ? 32'h100 : 32'h200);
        finish_burst(!first_d);

        // 4: reset during beat 2 of a D write aborts the burst
        d_addr = 32'h80;
        d_wen  = 1'b1;
        d_req  = 1'b1;
        step();
        for (int c = 1; c < 8; c++) step();
        check("t4_beat2", {30'd0, beat}, 32'd2);
        reset = 1'b1;
        step();
        check("t4_abort", {29'd0, d_gnt, m_wen, d_done}, 32'd0);
        reset = 1'b0;
        step();
        check("t4_regnt", {31'd0, d_gnt}, 32'd1);
        check("t4_beat0", {30'd0, beat}, 32'd0);
        check("t4_maddr", maddr, 32'h80);
        finish_burst(1'b1);
        d_wen = 1'b0;

        // 5: I holds req through RELEASE and is granted again
        i_addr = 32'h2000;
        i_req  = 1'b1;
        step();
        check("t5_gnt", {31'd0, i_gnt}, 32'd1);
        got = 1'b0;
        gap = 0;
        low = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            step();
            if (!i_gnt) begin
                low++;
            end else if (low > 0) begin
                got = 1'b1;
                gap = k;
            end
        end
        check("t5_regrant_seen", {31'd0, got}, 32'd1);
        check("t5_gap", 32'(gap), 32'd14);
        check("t5_low_cycles", 32'(low), 32'd2);
        check("t5_same_owner", {31'd0, d_gnt}, 32'd0);
        check("t5_maddr", maddr, 32'h2000);
        finish_burst(1'b0);

        // 6: MEM_LATENCY=0, every burst cycle commits
        b_i_addr = 32'h3008;
        b_i_req  = 1'b1;
        step();
        for (int c = 1; c <= 4; c++) begin
            check("t6_valid", {31'd0, b_i_valid}, 32'd1);
            check("t6_done", {31'd0, b_i_done}, {31'd0, (c == 4)});
            check("t6_stall", {31'd0, b_stall}, {31'd0, (c != 4)});
            check("t6_maddr", b_maddr, 32'h3000 + 32'(4 * (c - 1)));
            if (c == 4) b_i_req = 1'b0;
            step();
        end
        check("t6_release", {29'd0, b_i_gnt, b_i_valid, b_i_done}, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
